// File: rtl/fp_mac_acc_pipe_if.sv
// Operand/result stream bundle for the floating-point MAC engine.
// The master drives operand beats and result acceptance; the slave is the engine.
interface fp_mac_acc_pipe_if #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_first;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic [1:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, in_first, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_first, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_flags
  );
endinterface

// File: rtl/fp_mac_acc_pipe.sv
// Two-stage floating-point multiply-accumulate engine for dot products.
// Stage 1 forms the normalised product, stage 2 aligns it against the
// accumulator, adds, renormalises and either keeps or emits the sum.
// Format: {sign, exp, man}, no subnormals, exp 0 = zero, all-ones exp = max
// finite, truncation toward zero, saturation on overflow, flush on underflow.
module fp_mac_acc_pipe #(
  parameter int EXP_W = 5,
  parameter int MAN_W = 10,
  parameter int GRD_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  fp_mac_acc_pipe_if.slave   bus
);
  localparam int W      = 1 + EXP_W + MAN_W;
  localparam int M      = MAN_W + 1 + GRD_W;   // significand incl. hidden bit and guards
  localparam int XW     = EXP_W + 2;           // signed intermediate exponent width
  localparam int PW     = 2 * (MAN_W + 1);     // raw product width
  localparam int LZ_W   = $clog2(M + 2);
  localparam int RW     = 2 + 1 + EXP_W + M;   // {ovf, unf, s, e, m}
  localparam logic signed [XW-1:0] BIAS_S   = XW'(2**(EXP_W-1) - 1);
  localparam logic signed [XW-1:0] EMAX_S   = XW'(2**EXP_W - 2);
  localparam logic signed [XW-1:0] ONE_S    = XW'(1);
  localparam logic [EXP_W-1:0]     EMAX_U   = EXP_W'(2**EXP_W - 2);
  localparam logic [EXP_W-1:0]     SH_MAX_U = EXP_W'(MAN_W + GRD_W + 2);

  // Map an all-ones exponent onto the largest finite value; returns {exp, man}.
  function automatic logic [W-2:0] f_clamp_in(input logic [W-1:0] x);
    if (&x[W-2 -: EXP_W]) return {EMAX_U, {MAN_W{1'b1}}};
    return x[W-2:0];
  endfunction

  // Saturate / flush a normalised value and report {ovf, unf} alongside it.
  function automatic logic [RW-1:0] f_sat(input logic s, input logic signed [XW-1:0] e,
                                          input logic [M-1:0] m, input logic z);
    if (z)            return '0;
    if (e > EMAX_S)   return {2'b10, s, EMAX_U, {M{1'b1}}};
    if (e < ONE_S)    return {2'b01, 1'b0, {EXP_W{1'b0}}, {M{1'b0}}};
    return {2'b00, s, e[EXP_W-1:0], m};
  endfunction

  // Leading-zero count of the unnormalised adder result.
  function automatic logic [LZ_W-1:0] f_lzc(input logic [M:0] v);
    logic [LZ_W-1:0] n;
    logic            found;
    n     = '0;
    found = 1'b0;
    for (int i = M; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n     = n + 1'b1;
      end
    end
    return n;
  endfunction

  // ---------------- control ----------------
  logic             r_run;
  logic             r_vld_p1;
  logic             r_first_p1;
  logic             r_last_p1;
  logic             r_out_vld;
  logic [W-1:0]     r_out_sum;
  logic [1:0]       r_out_fl;
  logic             r_acc_s;
  logic [EXP_W-1:0] r_acc_e;
  logic [M-1:0]     r_acc_m;
  logic [1:0]       r_acc_fl;

  logic w_stall;
  logic w_s2_fire;
  logic w_accept;

  // A last beat cannot retire while an unaccepted result occupies the output.
  assign w_stall       = r_vld_p1 & r_last_p1 & r_out_vld & ~bus.out_ready;
  assign w_s2_fire     = r_vld_p1 & ~w_stall;
  assign bus.in_ready  = r_run & ~rst & ~w_stall;
  assign w_accept      = bus.in_valid & bus.in_ready;
  assign bus.out_valid = r_out_vld;
  assign bus.out_sum   = r_out_sum;
  assign bus.out_flags = r_out_fl;

  // ---------------- stage 1: product ----------------
  logic [W-2:0]           w_a_c;
  logic [W-2:0]           w_b_c;
  logic [PW-1:0]          w_prod;
  logic [M-1:0]           w_pm;
  logic signed [XW-1:0]   w_pe;
  logic                   w_pz;
  logic [RW-1:0]          w_p_pack;

  assign w_a_c  = f_clamp_in(bus.in_a);
  assign w_b_c  = f_clamp_in(bus.in_b);
  assign w_prod = {{(MAN_W+1){1'b0}}, 1'b1, w_a_c[MAN_W-1:0]}
                * {{(MAN_W+1){1'b0}}, 1'b1, w_b_c[MAN_W-1:0]};
  // Product lies in [1,4): a carry into the top bit means normalise right by one.
  assign w_pm   = w_prod[PW-1] ? w_prod[PW-1 -: M] : w_prod[PW-2 -: M];
  assign w_pe   = $signed({2'b00, w_a_c[W-2 -: EXP_W]}) + $signed({2'b00, w_b_c[W-2 -: EXP_W]})
                - BIAS_S + $signed({{(XW-1){1'b0}}, w_prod[PW-1]});
  assign w_pz   = (bus.in_a[W-2 -: EXP_W] == '0) | (bus.in_b[W-2 -: EXP_W] == '0);
  assign w_p_pack = f_sat(bus.in_a[W-1] ^ bus.in_b[W-1], w_pe, w_pm, w_pz);

  logic             r_s_p1;
  logic [EXP_W-1:0] r_e_p1;
  logic [M-1:0]     r_m_p1;
  logic [1:0]       r_fl_p1;

  // Capture the saturated product of each accepted beat.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_first_p1 <= bus.in_first;
      r_last_p1  <= bus.in_last;
      r_s_p1     <= w_p_pack[RW-3];
      r_e_p1     <= w_p_pack[M+EXP_W-1 -: EXP_W];
      r_m_p1     <= w_p_pack[M-1:0];
      r_fl_p1    <= w_p_pack[RW-1 -: 2];
    end
  end

  // ---------------- stage 2: align, add, normalise ----------------
  logic             w_as;
  logic [EXP_W-1:0] w_ae;
  logic [M-1:0]     w_am;
  logic             w_p_big;
  logic             w_big_s, w_sml_s;
  logic [EXP_W-1:0] w_big_e, w_sml_e, w_d;
  logic [M-1:0]     w_big_m, w_sml_m, w_sml_sh;
  logic [M:0]       w_raw;
  logic [LZ_W-1:0]  w_lz;
  logic [M:0]       w_norm;
  logic signed [XW-1:0] w_se;
  logic [RW-1:0]    w_sum_pack;
  logic [1:0]       w_fl_new;

  // A first beat sees +0 in place of whatever the accumulator holds.
  assign w_as = r_first_p1 ? 1'b0 : r_acc_s;
  assign w_ae = r_first_p1 ? '0   : r_acc_e;
  assign w_am = r_first_p1 ? '0   : r_acc_m;

  assign w_p_big  = {r_e_p1, r_m_p1} >= {w_ae, w_am};
  assign w_big_s  = w_p_big ? r_s_p1 : w_as;
  assign w_big_e  = w_p_big ? r_e_p1 : w_ae;
  assign w_big_m  = w_p_big ? r_m_p1 : w_am;
  assign w_sml_s  = w_p_big ? w_as   : r_s_p1;
  assign w_sml_e  = w_p_big ? w_ae   : r_e_p1;
  assign w_sml_m  = w_p_big ? w_am   : r_m_p1;
  assign w_d      = w_big_e - w_sml_e;
  assign w_sml_sh = (w_d > SH_MAX_U) ? '0 : (w_sml_m >> w_d);
  assign w_raw    = (w_big_s == w_sml_s) ? ({1'b0, w_big_m} + {1'b0, w_sml_sh})
                                         : ({1'b0, w_big_m} - {1'b0, w_sml_sh});
  assign w_lz     = f_lzc(w_raw);
  assign w_norm   = w_raw << w_lz;
  // Bit M of w_raw carries weight 2**(big_e+1); each leading zero drops one.
  assign w_se     = $signed({2'b00, w_big_e}) + ONE_S - $signed({{(XW-LZ_W){1'b0}}, w_lz});
  assign w_sum_pack = f_sat(w_big_s, w_se, w_norm[M:1], w_raw == '0);
  assign w_fl_new = (r_first_p1 ? 2'b00 : r_acc_fl) | r_fl_p1 | w_sum_pack[RW-1 -: 2];

  // Pipe valid, accumulator and result register; a last beat emits and clears the sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_run     <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_out_vld <= 1'b0;
      r_out_sum <= '0;
      r_out_fl  <= '0;
      r_acc_s   <= 1'b0;
      r_acc_e   <= '0;
      r_acc_m   <= '0;
      r_acc_fl  <= '0;
    end else begin
      r_run <= 1'b1;
      if (!w_stall) r_vld_p1 <= w_accept;
      if (w_s2_fire) begin
        if (r_last_p1) begin
          r_acc_s  <= 1'b0;
          r_acc_e  <= '0;
          r_acc_m  <= '0;
          r_acc_fl <= '0;
        end else begin
          r_acc_s  <= w_sum_pack[RW-3];
          r_acc_e  <= w_sum_pack[M+EXP_W-1 -: EXP_W];
          r_acc_m  <= w_sum_pack[M-1:0];
          r_acc_fl <= w_fl_new;
        end
      end
      if (w_s2_fire && r_last_p1) begin
        r_out_vld <= 1'b1;
        r_out_sum <= {w_sum_pack[RW-3], w_sum_pack[M+EXP_W-1 -: EXP_W], w_sum_pack[M-2 -: MAN_W]};
        r_out_fl  <= w_fl_new;
      end else if (bus.out_ready) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  // Bits dropped by truncation.
  logic w_unused;
  assign w_unused = ^{w_norm[0], w_prod[PW-M-2:0]};
endmodule
